// File: rtl/axi_mem_responder_if.sv
// AXI4 memory-port bundle between an AXI master and axi_mem_responder.
// Signal names follow the s_axi_mem_* port naming of the memory slave.
interface axi_mem_responder_if;
    logic         s_axi_mem_AWID;
    logic [63:0]  s_axi_mem_AWADDR;
    logic [7:0]   s_axi_mem_AWLEN;
    logic [1:0]   s_axi_mem_AWBURST;
    logic [2:0]   s_axi_mem_AWSIZE;
    logic [3:0]   s_axi_mem_AWCACHE;
    logic         s_axi_mem_AWLOCK;
    logic [2:0]   s_axi_mem_AWPROT;
    logic [3:0]   s_axi_mem_AWQOS;
    logic         s_axi_mem_AWVALID;
    logic         s_axi_mem_AWREADY;
    logic [255:0] s_axi_mem_WDATA;
    logic [31:0]  s_axi_mem_WSTRB;
    logic         s_axi_mem_WLAST;
    logic         s_axi_mem_WVALID;
    logic         s_axi_mem_WREADY;
    logic         s_axi_mem_BID;
    logic [1:0]   s_axi_mem_BRESP;
    logic         s_axi_mem_BVALID;
    logic         s_axi_mem_BREADY;
    logic         s_axi_mem_ARID;
    logic [63:0]  s_axi_mem_ARADDR;
    logic [7:0]   s_axi_mem_ARLEN;
    logic [1:0]   s_axi_mem_ARBURST;
    logic [2:0]   s_axi_mem_ARSIZE;
    logic [3:0]   s_axi_mem_ARCACHE;
    logic         s_axi_mem_ARLOCK;
    logic [2:0]   s_axi_mem_ARPROT;
    logic [3:0]   s_axi_mem_ARQOS;
    logic         s_axi_mem_ARVALID;
    logic         s_axi_mem_ARREADY;
    logic         s_axi_mem_RID;
    logic [255:0] s_axi_mem_RDATA;
    logic [1:0]   s_axi_mem_RRESP;
    logic         s_axi_mem_RLAST;
    logic         s_axi_mem_RVALID;
    logic         s_axi_mem_RREADY;

    modport slave (
        input  s_axi_mem_AWID, s_axi_mem_AWADDR, s_axi_mem_AWLEN,
        input  s_axi_mem_AWBURST, s_axi_mem_AWSIZE, s_axi_mem_AWCACHE,
        input  s_axi_mem_AWLOCK, s_axi_mem_AWPROT, s_axi_mem_AWQOS,
        input  s_axi_mem_AWVALID,
        output s_axi_mem_AWREADY,
        input  s_axi_mem_WDATA, s_axi_mem_WSTRB, s_axi_mem_WLAST,
        input  s_axi_mem_WVALID,
        output s_axi_mem_WREADY,
        output s_axi_mem_BID, s_axi_mem_BRESP, s_axi_mem_BVALID,
        input  s_axi_mem_BREADY,
        input  s_axi_mem_ARID, s_axi_mem_ARADDR, s_axi_mem_ARLEN,
        input  s_axi_mem_ARBURST, s_axi_mem_ARSIZE, s_axi_mem_ARCACHE,
        input  s_axi_mem_ARLOCK, s_axi_mem_ARPROT, s_axi_mem_ARQOS,
        input  s_axi_mem_ARVALID,
        output s_axi_mem_ARREADY,
        output s_axi_mem_RID, s_axi_mem_RDATA, s_axi_mem_RRESP,
        output s_axi_mem_RLAST, s_axi_mem_RVALID,
        input  s_axi_mem_RREADY
    );

    modport master (
        output s_axi_mem_AWID, s_axi_mem_AWADDR, s_axi_mem_AWLEN,
        output s_axi_mem_AWBURST, s_axi_mem_AWSIZE, s_axi_mem_AWCACHE,
        output s_axi_mem_AWLOCK, s_axi_mem_AWPROT, s_axi_mem_AWQOS,
        output s_axi_mem_AWVALID,
        input  s_axi_mem_AWREADY,
        output s_axi_mem_WDATA, s_axi_mem_WSTRB, s_axi_mem_WLAST,
        output s_axi_mem_WVALID,
        input  s_axi_mem_WREADY,
        input  s_axi_mem_BID, s_axi_mem_BRESP, s_axi_mem_BVALID,
        output s_axi_mem_BREADY,
        output s_axi_mem_ARID, s_axi_mem_ARADDR, s_axi_mem_ARLEN,
        output s_axi_mem_ARBURST, s_axi_mem_ARSIZE, s_axi_mem_ARCACHE,
        output s_axi_mem_ARLOCK, s_axi_mem_ARPROT, s_axi_mem_ARQOS,
        output s_axi_mem_ARVALID,
        input  s_axi_mem_ARREADY,
        input  s_axi_mem_RID, s_axi_mem_RDATA, s_axi_mem_RRESP,
        input  s_axi_mem_RLAST, s_axi_mem_RVALID,
        output s_axi_mem_RREADY
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a 256-bit word memory; INCR bursts only,
// independent read and write engines sharing the array.
module axi_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    axi_mem_responder_if.slave   axi
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [255:0] INIT_WORD =
        (INIT_ZERO != 0) ? '0 : {8{32'hDEADBEEF}};

    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
    typedef enum logic {R_IDLE, R_DATA} rdst_t;

    // Power-up contents only; reset never touches the array.
    logic [255:0] r_mem [DEPTH] = '{default: INIT_WORD};

    wst_t         r_wst;
    logic         r_awready;
    logic         r_wready;
    logic         r_bvalid;
    logic [1:0]   r_bresp;
    logic         r_bid;
    idx_t         r_widx;
    logic [8:0]   r_wbeats;
    logic         r_werr;
    logic         r_wlast_seen;

    rdst_t        r_rdst;
    logic         r_arready;
    logic         r_rvalid;
    logic         r_rlast;
    logic [1:0]   r_rresp;
    logic         r_rid;
    logic [255:0] r_rdata;
    idx_t         r_ridx;
    logic [8:0]   r_rbeats;
    logic         r_rerr;

    logic w_aw_fire;
    logic w_w_fire;
    logic w_b_fire;
    logic w_ar_fire;
    logic w_r_load;
    logic w_r_done;

    assign w_aw_fire = axi.s_axi_mem_AWVALID && r_awready;
    assign w_w_fire  = axi.s_axi_mem_WVALID && r_wready;
    assign w_b_fire  = r_bvalid && axi.s_axi_mem_BREADY;
    assign w_ar_fire = axi.s_axi_mem_ARVALID && r_arready;
    assign w_r_load  = (r_rdst == R_DATA) && (r_rbeats != 9'd0) &&
                       (!r_rvalid || axi.s_axi_mem_RREADY);
    assign w_r_done  = r_rvalid && r_rlast && axi.s_axi_mem_RREADY;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wst        <= W_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= OKAY;
            r_bid        <= 1'b0;
            r_widx       <= '0;
            r_wbeats     <= 9'd0;
            r_werr       <= 1'b0;
            r_wlast_seen <= 1'b0;
        end else begin
            unique case (r_wst)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_fire) begin
                        r_bid        <= axi.s_axi_mem_AWID;
                        r_widx       <= axi.s_axi_mem_AWADDR[5 +: DEPTH_LOG2];
                        r_wbeats     <= {1'b0, axi.s_axi_mem_AWLEN} + 9'd1;
                        r_werr       <= axi.s_axi_mem_AWBURST != INCR;
                        r_wlast_seen <= 1'b0;
                        r_awready    <= 1'b0;
                        r_wready     <= 1'b1;
                        r_wst        <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_fire) begin
                        r_widx   <= r_widx + idx_t'(1);
                        r_wbeats <= r_wbeats - 9'd1;
                        if (axi.s_axi_mem_WLAST) r_wlast_seen <= 1'b1;
                        // Burst length comes from AWLEN; WLAST only grades it.
                        if (r_wbeats == 9'd1) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || !axi.s_axi_mem_WLAST ||
                                         r_wlast_seen) ? SLVERR : OKAY;
                            r_wst    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_fire) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wst     <= W_IDLE;
                    end
                end
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_w_fire && !r_werr) begin
            for (int i = 0; i < 32; i++) begin
                if (axi.s_axi_mem_WSTRB[i])
                    r_mem[r_widx][i*8 +: 8] <= axi.s_axi_mem_WDATA[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rdst    <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= OKAY;
            r_rid     <= 1'b0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rbeats  <= 9'd0;
            r_rerr    <= 1'b0;
        end else begin
            unique case (r_rdst)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_fire) begin
                        r_rid     <= axi.s_axi_mem_ARID;
                        r_ridx    <= axi.s_axi_mem_ARADDR[5 +: DEPTH_LOG2];
                        r_rbeats  <= {1'b0, axi.s_axi_mem_ARLEN} + 9'd1;
                        r_rerr    <= axi.s_axi_mem_ARBURST != INCR;
                        r_arready <= 1'b0;
                        r_rdst    <= R_DATA;
                    end
                end
                R_DATA: begin
                    // Array read sees pre-write data on a same-cycle collision.
                    if (w_r_load) begin
                        r_rdata  <= r_rerr ? '0 : r_mem[r_ridx];
                        r_rresp  <= r_rerr ? SLVERR : OKAY;
                        r_rlast  <= r_rbeats == 9'd1;
                        r_rvalid <= 1'b1;
                        r_ridx   <= r_ridx + idx_t'(1);
                        r_rbeats <= r_rbeats - 9'd1;
                    end else if (w_r_done) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rdst    <= R_IDLE;
                    end
                end
                default: r_rdst <= R_IDLE;
            endcase
        end
    end

    assign axi.s_axi_mem_AWREADY = r_awready;
    assign axi.s_axi_mem_WREADY  = r_wready;
    assign axi.s_axi_mem_BVALID  = r_bvalid;
    assign axi.s_axi_mem_BRESP   = r_bresp;
    assign axi.s_axi_mem_BID     = r_bid;
    assign axi.s_axi_mem_ARREADY = r_arready;
    assign axi.s_axi_mem_RVALID  = r_rvalid;
    assign axi.s_axi_mem_RLAST   = r_rlast;
    assign axi.s_axi_mem_RRESP   = r_rresp;
    assign axi.s_axi_mem_RID     = r_rid;
    assign axi.s_axi_mem_RDATA   = r_rdata;

    logic w_unused;
    assign w_unused = &{1'b0,
        axi.s_axi_mem_AWADDR[63:5+DEPTH_LOG2], axi.s_axi_mem_AWADDR[4:0],
        axi.s_axi_mem_ARADDR[63:5+DEPTH_LOG2], axi.s_axi_mem_ARADDR[4:0],
        axi.s_axi_mem_AWSIZE, axi.s_axi_mem_AWCACHE, axi.s_axi_mem_AWLOCK,
        axi.s_axi_mem_AWPROT, axi.s_axi_mem_AWQOS,
        axi.s_axi_mem_ARSIZE, axi.s_axi_mem_ARCACHE, axi.s_axi_mem_ARLOCK,
        axi.s_axi_mem_ARPROT, axi.s_axi_mem_ARQOS};
endmodule
